stereo_frame_gen: RTL and testbench
===================================

# stereo_frame_gen

Synthetic stereo camera source: generates the line/frame sync (Href, Vsync) and the left/right grayscale pixel streams that the stereo disparity pipeline consumes. The right image is the left image shifted by a programmable, known disparity. This gives a self-checking stimulus path for the disparity core on the bench, and a camera-free bring-up path on the board. It sits where the two cameras normally attach and drives the pipeline's `iGrayL`, `iGrayR`, `iHref` and `iVsync` inputs directly.

## Interface

Parameters (counts are minus-one, matching the pipeline):

- `PIXEL_DEPTH`, 15: pixel width − 1.
- `PX_CNT_DEPTH`, 8: pixel-counter width − 1.
- `LINE_CNT_DEPTH`, 9: line-counter width − 1.
- `PIXELS_PER_LINE`, 449: active pixels per line − 1.
- `LINES_PER_FRAME`, 374: active lines per frame − 1.
- `HBLANK`, 39: Href-low cycles after each active line − 1.
- `VSYNC_LINES`, 2: line periods with Vsync high − 1.
- `VBLANK_LINES`, 1: back-porch line periods (Vsync low, Href low) − 1.
- `DISPARITY_DEPTH`, 6: disparity width − 1.

Ports:

- `pxclk` in 1: pixel clock; all logic on rising edge.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `iRun` in 1: level; frames are generated while high.
- `iMode` in 2: pattern select, latched at frame start.
- `iDisparity` in DISPARITY_DEPTH+1: right-image shift D, latched at frame start.
- `oGrayL` out PIXEL_DEPTH+1: left pixel.
- `oGrayR` out PIXEL_DEPTH+1: right pixel.
- `oHref` out 1: high during active pixels.
- `oVsync` out 1: high during vertical sync.
- `oPxCount` out PX_CNT_DEPTH+1: active column x; 0 outside active.
- `oLineCount` out LINE_CNT_DEPTH+1: active line y; 0 outside active.
- `oBusy` out 1: high in any state other than IDLE.
- `oFrameDone` out 1: one-cycle pulse after the last active pixel of a frame.

## Operation

States: IDLE → VSYNC → VBLANK → ACTIVE → (VSYNC if `iRun`, else IDLE).

- Line period is P = (PIXELS_PER_LINE+1) + (HBLANK+1) cycles, tracked by an internal horizontal counter h.
- **IDLE:** all outputs 0. When `iRun`=1, latch `iMode` and `iDisparity`, clear h, and go to VSYNC.
- **VSYNC:** `oVsync`=1 and `oHref`=0 for (VSYNC_LINES+1)·P cycles.
- **VBLANK:** `oVsync`=0 and `oHref`=0 for (VBLANK_LINES+1)·P cycles.
- **ACTIVE:** per line, `oHref`=1 for h ∈ [0, PIXELS_PER_LINE] with x=h, then `oHref`=0 for HBLANK+1 cycles.
  - y increments at each line end.
  - After line LINES_PER_FRAME, pulse `oFrameDone` and move to the next state.
  - Exactly LINES_PER_FRAME+1 falling edges of Href occur per frame, all with Vsync low.
- **Left pixel** L(x,y), by `iMode`:
  - 0, ramp: ((y << (PX_CNT_DEPTH+1)) | x) truncated to PIXEL_DEPTH+1 bits.
  - 1, hash: low bits of ((x+1)·16'h9E37) XOR (y·16'h7F4A).
  - 2, bars: all-ones if x[3]=1, else 0.
  - 3, flat: 16'h8000.
- **Right pixel:** R(x,y) = L(x+D, y) if x+D ≤ PIXELS_PER_LINE, else 0.
  - Sum x+D is computed PX_CNT_DEPTH+2 wide, so there is no wraparound.
- `oGrayL`/`oGrayR` are 0 whenever `oHref`=0.
- `iRun` falling mid-frame: the current frame completes, including `oFrameDone`, then the block enters IDLE.
- `iRun` rising during the frame tail: it is ignored until the frame completes.
- `iMode` and `iDisparity` changes mid-frame: ignored until the next frame start.

## Timing

- All outputs are registered. Reset value of every output is 0, and the state resets to IDLE.
- `reset_n` low forces all outputs to 0 asynchronously, including mid-line. After release, the block restarts from IDLE.
- Start latency: with `iRun` high in IDLE at edge k, `oVsync`=1 from edge k+1.
- At the VSYNC → VBLANK boundary, `oVsync` falls on the cycle following the last VSYNC cycle.
- Href, pixels, `oPxCount` and `oLineCount` all change on the same edge, so they are mutually aligned.
- `oFrameDone` is high for the one cycle immediately after the last active pixel (x=PIXELS_PER_LINE, y=LINES_PER_FRAME), coincident with the first HBLANK cycle.
- Frame length is (VSYNC_LINES+1 + VBLANK_LINES+1 + LINES_PER_FRAME+1)·P cycles. Back-to-back frames have no gap cycles.

## Test plan

- **Reset:** hold `reset_n`=0 for 5 cycles with `iRun`=1, then release. Required: all outputs 0 during reset; `oVsync`=1 on the 2nd edge after release.
- **Single frame with defaults, mode 0:** `iRun` pulsed for 1 cycle. Required:
  - Vsync high for 3·490 cycles.
  - 375 Href pulses of 450 cycles each, 40-cycle gaps between them.
  - `oFrameDone` pulses exactly once.
  - Return to IDLE with `oBusy`=0.
- **Ramp values:** mode 0, D=0. At x=17, y=3, `oGrayL` and `oGrayR` both equal 16'h0611.
- **Disparity:** mode 1, D=5. At every active pixel, `oGrayR`(x)=`oGrayL`(x+5). At x=445..449, `oGrayR`=0.
- **Latching and stop:** change `iDisparity` from 5 to 20 mid-frame, and drop `iRun` on line 100. Required: the rest of that frame still uses D=5, the frame completes, and the block goes to IDLE.
- **Reset mid-operation:** assert `reset_n`=0 at x=200, y=50. Required: all outputs 0 within the same cycle; after release with `iRun`=1, a fresh frame starts at VSYNC.

Source files
------------

// File: rtl/stereo_frame_gen.sv
// Synthetic stereo source: Vsync/Href timing plus left/right gray patterns,
// with the right image equal to the left image shifted by a latched disparity.
module stereo_frame_gen #(
  parameter int PIXEL_DEPTH     = 15,
  parameter int PX_CNT_DEPTH    = 8,
  parameter int LINE_CNT_DEPTH  = 9,
  parameter int PIXELS_PER_LINE = 449,
  parameter int LINES_PER_FRAME = 374,
  parameter int HBLANK          = 39,
  parameter int VSYNC_LINES     = 2,
  parameter int VBLANK_LINES    = 1,
  parameter int DISPARITY_DEPTH = 6
) (
  input  logic                      pxclk,
  input  logic                      reset_n,
  input  logic                      iRun,
  input  logic [1:0]                iMode,
  input  logic [DISPARITY_DEPTH:0]  iDisparity,
  output logic [PIXEL_DEPTH:0]      oGrayL,
  output logic [PIXEL_DEPTH:0]      oGrayR,
  output logic                      oHref,
  output logic                      oVsync,
  output logic [PX_CNT_DEPTH:0]     oPxCount,
  output logic [LINE_CNT_DEPTH:0]   oLineCount,
  output logic                      oBusy,
  output logic                      oFrameDone
);
  localparam int P  = PIXELS_PER_LINE + HBLANK + 2;
  localparam int HW = $clog2(P);
  localparam int XW = PX_CNT_DEPTH + 1;
  localparam int YW = LINE_CNT_DEPTH + 1;
  localparam int PW = PIXEL_DEPTH + 1;

  typedef enum logic [1:0] {IDLE, VSYNC, VBLANK, ACTIVE} state_t;

  state_t                 state, state_nx;
  logic [HW-1:0]          h, h_nx;
  logic [YW-1:0]          ln, ln_nx;
  logic [1:0]             mode;
  logic [DISPARITY_DEPTH:0] disp;
  logic                   latch, line_end, act, r_ok;
  logic [XW-1:0]          x;
  logic [XW:0]            xs;

  function automatic logic [PW-1:0] pix(input logic [1:0] m, input logic [XW-1:0] px,
                                        input logic [YW-1:0] py);
    logic [31:0] r;
    case (m)
      2'd0:    r = (32'(py) << XW) | 32'(px);
      2'd1:    r = ((32'(px) + 32'd1) * 32'h9E37) ^ (32'(py) * 32'h7F4A);
      2'd2:    r = px[3] ? '1 : '0;
      default: r = 32'(1) << PIXEL_DEPTH;
    endcase
    return r[PW-1:0];
  endfunction

  assign line_end = (h == HW'(P - 1));

  // ln counts line periods within the current phase; in ACTIVE it is y.
  always_comb begin
    state_nx = state;
    h_nx     = h;
    ln_nx    = ln;
    latch    = 1'b0;
    case (state)
      IDLE: if (iRun) begin
        state_nx = VSYNC;
        h_nx     = '0;
        ln_nx    = '0;
        latch    = 1'b1;
      end
      default: begin
        h_nx = line_end ? '0 : h + 1'b1;
        if (line_end) begin
          ln_nx = ln + 1'b1;
          case (state)
            VSYNC:  if (ln == YW'(VSYNC_LINES))  begin state_nx = VBLANK; ln_nx = '0; end
            VBLANK: if (ln == YW'(VBLANK_LINES)) begin state_nx = ACTIVE; ln_nx = '0; end
            ACTIVE: if (ln == YW'(LINES_PER_FRAME)) begin
              ln_nx    = '0;
              state_nx = iRun ? VSYNC : IDLE;
              latch    = iRun;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  assign act  = (state == ACTIVE) && (h <= HW'(PIXELS_PER_LINE));
  assign x    = XW'(h);
  // One extra bit so x+D never wraps back into the active range.
  assign xs   = {1'b0, x} + (XW+1)'(disp);
  assign r_ok = (xs <= (XW+1)'(PIXELS_PER_LINE));

  always_ff @(posedge pxclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      h          <= '0;
      ln         <= '0;
      mode       <= '0;
      disp       <= '0;
      oGrayL     <= '0;
      oGrayR     <= '0;
      oHref      <= 1'b0;
      oVsync     <= 1'b0;
      oPxCount   <= '0;
      oLineCount <= '0;
      oBusy      <= 1'b0;
      oFrameDone <= 1'b0;
    end else begin
      state <= state_nx;
      h     <= h_nx;
      ln    <= ln_nx;
      if (latch) begin
        mode <= iMode;
        disp <= iDisparity;
      end
      oVsync     <= (state == VSYNC);
      oHref      <= act;
      oPxCount   <= act ? x : '0;
      oLineCount <= act ? ln : '0;
      oGrayL     <= act ? pix(mode, x, ln) : '0;
      oGrayR     <= (act && r_ok) ? pix(mode, xs[XW-1:0], ln) : '0;
      oBusy      <= (state != IDLE);
      oFrameDone <= (state == ACTIVE) && (h == HW'(PIXELS_PER_LINE + 1)) &&
                    (ln == YW'(LINES_PER_FRAME));
    end
  end
endmodule

// File: tb/tb_stereo_frame_gen.sv
// Bench for stereo_frame_gen: reduced frame geometry, a time-indexed frame
// model compared every cycle, plus directed timing and pattern checks.
module tb_stereo_frame_gen;
  localparam int PPL = 49, LPF = 19, HB = 7, VSL = 2, VBL = 1;
  localparam int P = PPL + HB + 2, NVS = VSL + 1, NVB = VBL + 1;
  localparam int FRAME = (NVS + NVB + LPF + 1) * P;

  logic        pxclk = 0, reset_n = 0, iRun = 0;
  logic [1:0]  iMode = 0;
  logic [6:0]  iDisparity = 0;
  logic [15:0] oGrayL, oGrayR;
  logic        oHref, oVsync, oBusy, oFrameDone;
  logic [8:0]  oPxCount;
  logic [9:0]  oLineCount;

  stereo_frame_gen #(.PIXELS_PER_LINE(PPL), .LINES_PER_FRAME(LPF), .HBLANK(HB),
                     .VSYNC_LINES(VSL), .VBLANK_LINES(VBL)) dut (
    .pxclk(pxclk), .reset_n(reset_n), .iRun(iRun), .iMode(iMode), .iDisparity(iDisparity),
    .oGrayL(oGrayL), .oGrayR(oGrayR), .oHref(oHref), .oVsync(oVsync),
    .oPxCount(oPxCount), .oLineCount(oLineCount), .oBusy(oBusy), .oFrameDone(oFrameDone));

  always #5 pxclk = ~pxclk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned lpix(input int m, input int px, input int py);
    case (m)
      0:       return (py * 512 + px) & 32'hFFFF;
      1:       return (((px + 1) * 32'h9E37) ^ (py * 32'h7F4A)) & 32'hFFFF;
      2:       return ((px / 8) % 2 == 1) ? 32'hFFFF : 0;
      default: return 32'h8000;
    endcase
  endfunction

  logic [63:0] got_vec;
  assign got_vec = 64'({oGrayL, oGrayR, oHref, oVsync, oPxCount, oLineCount, oBusy, oFrameDone});

  // Model: mt is the cycle index within the frame (-1 when idle); outputs
  // appear one edge after the position they describe.
  int mt = -1, mm = 0, md = 0, m_ln, m_h, m_y;
  int unsigned e_gl, e_gr;
  bit m_act;
  logic [63:0] expv = '0;
  always @(posedge pxclk or negedge reset_n) begin
    if (!reset_n) begin
      mt = -1; expv = '0;
    end else begin
      expv = '0;
      if (mt >= 0) begin
        m_ln = mt / P; m_h = mt % P; m_y = m_ln - NVS - NVB;
        m_act = (m_y >= 0) && (m_h <= PPL);
        e_gl = m_act ? lpix(mm, m_h, m_y) : 0;
        e_gr = (m_act && (m_h + md <= PPL)) ? lpix(mm, m_h + md, m_y) : 0;
        expv = 64'({16'(e_gl), 16'(e_gr), m_act, m_ln < NVS, 9'(m_act ? m_h : 0),
                    10'(m_act ? m_y : 0), 1'b1, (m_y == LPF) && (m_h == PPL + 1)});
      end
      if (mt < 0 || mt == FRAME - 1) begin
        if (iRun) begin mt = 0; mm = int'(iMode); md = int'(iDisparity); end
        else mt = -1;
      end else mt++;
    end
  end

  bit mchk = 0;
  always @(negedge pxclk) if (mchk) chk("outs", got_vec, expv);

  // Frame-structure monitor.
  int vs_run = 0, hi_run = 0, lo_run = 0, pulses = 0, fd_total = 0;
  logic pv = 0, ph = 0;
  bit seen_fall = 0;
  always @(negedge pxclk) begin
    if (!reset_n) begin
      vs_run = 0; hi_run = 0; lo_run = 0; pulses = 0; pv = 0; ph = 0; seen_fall = 0;
    end else begin
      if (oVsync) vs_run = pv ? vs_run + 1 : 1;
      else if (pv) chk("vs_len", 64'(vs_run), 64'(NVS * P));
      if (!pv && oVsync) begin pulses = 0; seen_fall = 0; end
      if (!ph && oHref && seen_fall) chk("href_gap", 64'(lo_run), 64'(HB + 1));
      if (oHref) hi_run = ph ? hi_run + 1 : 1;
      if (ph && !oHref) begin
        chk("href_len", 64'(hi_run), 64'(PPL + 1));
        chk("href_fall_vs", 64'(oVsync), 64'(0));
        pulses++; seen_fall = 1; lo_run = 0;
      end
      if (!oHref) lo_run++;
      if (oFrameDone) begin
        fd_total++;
        chk("frame_pulses", 64'(pulses), 64'(LPF + 1));
      end
      pv = oVsync; ph = oHref;
    end
  end

  task automatic wait_px(input int px, input int py, input string tag);
    int n = 0;
    while (!(oHref && oPxCount == 9'(px) && oLineCount == 10'(py)) && n < 3 * FRAME) begin
      @(negedge pxclk); n++;
    end
    chk(tag, 64'(n < 3 * FRAME), 64'(1));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (oBusy && n < 3 * FRAME) begin @(negedge pxclk); n++; end
    chk(tag, 64'(n < 3 * FRAME), 64'(1));
  endtask

  task automatic wait_fd(input string tag);
    int n = 0;
    while (!oFrameDone && n < 3 * FRAME) begin @(negedge pxclk); n++; end
    chk(tag, 64'(n < 3 * FRAME), 64'(1));
  endtask

  int fd0;
  initial begin
    // Reset held with iRun high, then release and a one-cycle run pulse.
    reset_n = 0; iRun = 1; mchk = 1;
    repeat (5) begin @(negedge pxclk); chk("rst_zero", got_vec, 64'(0)); end
    reset_n = 1;
    @(negedge pxclk); chk("start_vs0", 64'(oVsync), 64'(0));
    iRun = 0; fd0 = fd_total;
    @(negedge pxclk); chk("start_vs1", 64'(oVsync), 64'(1));
    chk("start_busy", 64'(oBusy), 64'(1));
    wait_idle("single_idle_tmo");
    chk("single_fd", 64'(fd_total - fd0), 64'(1));
    chk("single_busy", 64'(oBusy), 64'(0));

    // Ramp values, then queue mode 1 / D=5 for the following frame.
    iMode = 0; iDisparity = 0; iRun = 1;
    wait_px(17, 3, "ramp_tmo");
    chk("ramp_l", 64'(oGrayL), 64'h0611);
    chk("ramp_r", 64'(oGrayR), 64'h0611);
    iMode = 1; iDisparity = 5;
    wait_fd("ramp_fd_tmo");
    wait_px(0, 8, "disp_y8_tmo");
    iDisparity = 20; iRun = 0; fd0 = fd_total;
    wait_px(30, 12, "disp_x30_tmo");
    chk("disp_r30", 64'(oGrayR), 64'(lpix(1, 35, 12)));
    chk("disp_l30", 64'(oGrayL), 64'(lpix(1, 30, 12)));
    wait_px(45, 12, "disp_x45_tmo");
    for (int i = 0; i < 5; i++) begin
      chk("disp_edge_x", 64'(oPxCount), 64'(45 + i));
      chk("disp_edge_r", 64'(oGrayR), 64'(0));
      @(negedge pxclk);
    end
    wait_idle("stop_idle_tmo");
    chk("stop_fd", 64'(fd_total - fd0), 64'(1));
    chk("stop_busy", 64'(oBusy), 64'(0));

    // Random mode/disparity/run activity.
    iRun = 1;
    for (int c = 0; c < 12000; c++) begin
      @(negedge pxclk);
      if ($urandom_range(0, 199) == 0) iMode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) iDisparity = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 999) == 0) iRun = ~iRun;
    end

    // Asynchronous reset in the middle of an active line.
    iRun = 1; iMode = 3;
    wait_px(20, 5, "mid_tmo");
    #1 reset_n = 0;
    #1 chk("rst_async", got_vec, 64'(0));
    repeat (3) @(negedge pxclk);
    chk("rst_hold", got_vec, 64'(0));
    reset_n = 1;
    @(negedge pxclk); chk("restart_vs0", 64'(oVsync), 64'(0));
    @(negedge pxclk); chk("restart_vs1", 64'(oVsync), 64'(1));
    chk("restart_href", 64'(oHref), 64'(0));
    iRun = 0;
    wait_idle("final_idle_tmo");
    chk("final_busy", 64'(oBusy), 64'(0));
    mchk = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
